// File: rtl/iir_pkg.sv
// Shared types and constants for the IIR coefficient scheduler.
// A_DEFAULT is the coefficient set the section ran with before runtime loading.
package iir_pkg;

  localparam int N_COEF = 6;
  localparam int COEF_W = 15;
  localparam int ADDR_W = 3;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [N_COEF-1:0] coef_bank_t;

  // sfix15_En11: a[0] = 1.0, the rest small alternating taps
  localparam coef_bank_t A_DEFAULT = {
    coef_t'(-205),
    coef_t'(410),
    coef_t'(-819),
    coef_t'(1638),
    coef_t'(-3277),
    coef_t'(2048)
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/iir_coeff_bank.sv
// Shadow/active coefficient register pair.
// Writes land in the shadow; swap_i copies the whole shadow into active.
module iir_coeff_bank
  import iir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  coef_t             wr_data_i,
  input  logic              swap_i,
  output coef_bank_t        active_o
);

  coef_bank_t shadow_q;
  coef_bank_t shadow_d;
  coef_bank_t active_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < N_COEF; i++) begin
      if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
        shadow_d[i] = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= A_DEFAULT;
      active_q <= A_DEFAULT;
    end else begin
      shadow_q <= shadow_d;
      if (swap_i) begin
        active_q <= shadow_q;
      end
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/iir_coeff_sched.sv
// Runtime coefficient controller: config port, atomic bank swap on a
// sample boundary, optional delay-line flush and sample-enable gating.
module iir_coeff_sched
  import iir_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4,
  parameter int DROP_W       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [COEF_W-1:0]        cfg_data,
  input  logic                     cfg_commit,
  input  logic                     cfg_flush,
  output logic [N_COEF*COEF_W-1:0] a_out,
  output logic                     iir_en,
  output logic                     iir_clear,
  output logic                     busy,
  output logic                     err_addr,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_e            state_q, state_d;
  logic              flush_q, flush_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              ready_q;
  logic              iir_en_q;
  logic              clear_q;
  logic              busy_q;
  logic              err_q;
  logic [DROP_W-1:0] drop_q;

  logic       acc;
  logic       wr_beat;
  logic       wr_ok;
  logic       commit;
  logic       swap;
  logic       suppress;
  coef_bank_t active;

  // ready_q is only ever high while state_q is IDLE
  assign acc     = cfg_valid & ready_q;
  assign wr_beat = acc & ~cfg_commit;
  assign wr_ok   = wr_beat & (cfg_addr < ADDR_W'(N_COEF));
  assign commit  = acc & cfg_commit;

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    fcnt_d   = fcnt_q;
    swap     = 1'b0;
    suppress = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (commit) begin
          flush_d = cfg_flush;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (sample_en) begin
          swap     = 1'b1;
          suppress = 1'b1;
          fcnt_d   = '0;
          state_d  = flush_q ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        suppress = sample_en;
        if (fcnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      flush_q  <= 1'b0;
      fcnt_q   <= '0;
      ready_q  <= 1'b0;
      iir_en_q <= 1'b0;
      clear_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      fcnt_q   <= fcnt_d;
      ready_q  <= (state_d == IDLE);
      iir_en_q <= sample_en & ~suppress;
      clear_q  <= (state_d == FLUSH);
      busy_q   <= (state_d != IDLE);
      if (wr_beat && !wr_ok) begin
        err_q <= 1'b1;
      end
      if (suppress && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  iir_coeff_bank u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_ok),
    .wr_addr_i (cfg_addr),
    .wr_data_i (coef_t'(cfg_data)),
    .swap_i    (swap),
    .active_o  (active)
  );

  assign a_out     = active;
  assign cfg_ready = ready_q;
  assign iir_en    = iir_en_q;
  assign iir_clear = clear_q;
  assign busy      = busy_q;
  assign err_addr  = err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_iir_coeff_sched.sv
// Self-checking bench for iir_coeff_sched: table of config beats,
// strobe scoreboard, and hand sequences for flush, reset and saturation.
module tb_iir_coeff_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_commit = 1'b0;
  logic        cfg_flush = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [14:0] cfg_data = '0;
  logic        cfg_ready;
  logic        iir_en;
  logic        iir_clear;
  logic        busy;
  logic        err_addr;
  logic [89:0] a_out;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iir_coeff_sched dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_flush  (cfg_flush),
    .a_out      (a_out),
    .iir_en     (iir_en),
    .iir_clear  (iir_clear),
    .busy       (busy),
    .err_addr   (err_addr),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic        commit;
    logic        flush;
    logic [2:0]  addr;
    logic [14:0] data;
    logic        exp_err;
  } beat_t;

  beat_t       tbl[12];
  logic [14:0] def_a[6];
  logic [14:0] sh[6];
  logic [89:0] exp_a;
  int          exp_drop;
  bit          sbq[$];

  function automatic logic [89:0] pack(input logic [14:0] v[6]);
    logic [89:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*15 +: 15] = v[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [89:0] act,
                     input logic [89:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit pass, input bit swp);
    bit e;
    sample_en = 1'b1;
    sbq.push_back(pass);
    if (swp) exp_a = pack(sh);
    if (!pass && exp_drop < 255) exp_drop++;
    cyc();
    sample_en = 1'b0;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 90'(1), 90'(0));
    end else begin
      e = sbq.pop_front();
      chk("iir_en", 90'(iir_en), 90'(e));
    end
    chk("a_out", a_out, exp_a);
    chk("drop_cnt", 90'(drop_cnt), 90'(exp_drop));
  endtask

  task automatic beat(input beat_t b);
    cfg_valid  = 1'b1;
    cfg_commit = b.commit;
    cfg_flush  = b.flush;
    cfg_addr   = b.addr;
    cfg_data   = b.data;
    cyc();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    cfg_flush  = 1'b0;
    if (!b.commit && b.addr < 3'd6) sh[b.addr] = b.data;
    chk("err_addr", 90'(err_addr), 90'(b.exp_err));
  endtask

  initial begin
    def_a = '{15'h0800, 15'h7333, 15'h0666, 15'h7CCD, 15'h019A, 15'h7F33};
    sh = def_a;
    exp_a = pack(def_a);
    exp_drop = 0;

    tbl[0]  = '{1'b0, 1'b0, 3'd0, 15'h0800, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 3'd1, 15'h7FFF, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 3'd2, 15'h4000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 3'd3, 15'h7FFF, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 3'd4, 15'h0001, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 3'd5, 15'h4000, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 15'h0000, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 3'd3, 15'h0123, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 3'd0, 15'h0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 3'd6, 15'h1234, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 15'h7ABC, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 15'h0000, 1'b1};

    // reset state
    repeat (3) cyc();
    chk("rst_ready", 90'(cfg_ready), 90'(0));
    chk("rst_iir_en", 90'(iir_en), 90'(0));
    chk("rst_clear", 90'(iir_clear), 90'(0));
    chk("rst_busy", 90'(busy), 90'(0));
    chk("rst_err", 90'(err_addr), 90'(0));
    chk("rst_drop", 90'(drop_cnt), 90'(0));
    chk("rst_a_out", a_out, exp_a);
    reset = 1'b0;
    cyc();
    chk("ready_after_rst", 90'(cfg_ready), 90'(1));

    // idle strobes pass through as one-cycle pulses
    for (int k = 0; k < 3; k++) begin
      strobe(1'b1, 1'b0);
      cyc();
      chk("iir_en_width", 90'(iir_en), 90'(0));
      repeat (6) cyc();
    end

    // table of config beats; commits get a swap sequence
    for (int i = 0; i < 12; i++) begin
      beat(tbl[i]);
      if (tbl[i].commit) begin
        chk("busy_armed", 90'(busy), 90'(1));
        chk("ready_armed", 90'(cfg_ready), 90'(0));
        repeat (3) cyc();
        chk("a_out_hold", a_out, exp_a);
        strobe(1'b0, 1'b1);
        if (tbl[i].flush) begin
          chk("clear_c1", 90'(iir_clear), 90'(1));
          strobe(1'b0, 1'b0);
          chk("clear_c2", 90'(iir_clear), 90'(1));
          cyc();
          chk("clear_c3", 90'(iir_clear), 90'(1));
          cyc();
          chk("clear_c4", 90'(iir_clear), 90'(1));
          chk("busy_c4", 90'(busy), 90'(1));
          cyc();
          chk("clear_end", 90'(iir_clear), 90'(0));
          chk("busy_end", 90'(busy), 90'(0));
        end else begin
          chk("clear_noflush", 90'(iir_clear), 90'(0));
          chk("busy_noflush", 90'(busy), 90'(0));
        end
        repeat (4) cyc();
        strobe(1'b1, 1'b0);
        repeat (2) cyc();
      end
    end

    // write coincident with a strobe
    cfg_valid = 1'b1;
    cfg_addr = 3'd2;
    cfg_data = 15'h1111;
    strobe(1'b1, 1'b0);
    cfg_valid = 1'b0;
    sh[2] = 15'h1111;
    // commit coincident with a strobe: that strobe passes
    cfg_valid = 1'b1;
    cfg_commit = 1'b1;
    strobe(1'b1, 1'b0);
    cfg_valid = 1'b0;
    cfg_commit = 1'b0;
    chk("busy_coinc", 90'(busy), 90'(1));
    repeat (3) cyc();
    strobe(1'b0, 1'b1);
    repeat (3) cyc();

    // reset in flush cycle 2
    beat('{1'b1, 1'b1, 3'd0, 15'h0000, 1'b1});
    strobe(1'b0, 1'b1);
    cyc();
    chk("clear_pre_rst", 90'(iir_clear), 90'(1));
    reset = 1'b1;
    cyc();
    sh = def_a;
    exp_a = pack(def_a);
    exp_drop = 0;
    sbq.delete();
    chk("mid_rst_clear", 90'(iir_clear), 90'(0));
    chk("mid_rst_a_out", a_out, exp_a);
    chk("mid_rst_drop", 90'(drop_cnt), 90'(0));
    chk("mid_rst_busy", 90'(busy), 90'(0));
    chk("mid_rst_err", 90'(err_addr), 90'(0));
    reset = 1'b0;
    cyc();
    chk("ready_post_rst", 90'(cfg_ready), 90'(1));

    // drive 300 suppressions to saturate drop_cnt
    for (int n = 0; n < 60; n++) begin
      beat('{1'b1, 1'b1, 3'd0, 15'h0000, 1'b0});
      strobe(1'b0, 1'b1);
      repeat (4) strobe(1'b0, 1'b0);
    end
    chk("drop_sat", 90'(drop_cnt), 90'(255));
    cyc();
    strobe(1'b1, 1'b0);
    chk("drop_sat_hold", 90'(drop_cnt), 90'(255));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
